// File: rtl/requant_pkg.sv
// Shared definitions for the requant parameter scheduler and the requant datapath.
package requant_pkg;

    localparam logic [1:0] CFG_BIAS = 2'd0;
    localparam logic [1:0] CFG_M    = 2'd1;
    localparam logic [1:0] CFG_E    = 2'd2;
    localparam logic [1:0] CFG_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    localparam logic [3:0] KEEP_ALL = 4'b1111;

    // Depth of the requant input registers the A stream passes through.
    localparam int A_PIPE_DLY = 2;

    // Multiply and shift stages still in flight after the last accumulator.
    localparam int DRAIN_CYC = 2;

endpackage

// File: rtl/requant_param_tbl.sv
// Bias, M and E parameter storage: one config write port, combinational read by (head, col).
module requant_param_tbl
    import requant_pkg::*;
#(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 32,
    parameter int N_COLS  = 16,
    parameter int N_HEADS = 4,
    parameter int HW      = $clog2(N_HEADS),
    parameter int CW      = $clog2(N_COLS)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [1:0]         i_sel,
    input  logic [HW-1:0]      i_wr_head,
    input  logic [CW-1:0]      i_wr_col,
    input  logic [D_W_ACC-1:0] i_wr_data,
    input  logic [HW-1:0]      i_rd_head,
    input  logic [CW-1:0]      i_rd_col,
    output logic [D_W_ACC-1:0] o_bias,
    output logic [D_W_ACC-1:0] o_m,
    output logic [D_W-1:0]     o_e
);

    // Tables carry no reset: contents survive a scheduler reset.
    logic [D_W_ACC-1:0] r_bias [N_HEADS*N_COLS];
    logic [D_W_ACC-1:0] r_m    [N_HEADS];
    logic [D_W-1:0]     r_e    [N_HEADS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            case (i_sel)
                CFG_BIAS: r_bias[{i_wr_head, i_wr_col}] <= i_wr_data;
                CFG_M:    r_m[i_wr_head]                <= i_wr_data;
                CFG_E:    r_e[i_wr_head]                <= i_wr_data[D_W-1:0];
                default:  ;
            endcase
        end
    end

    assign o_bias = r_bias[{i_rd_head, i_rd_col}];
    assign o_m    = r_m[i_rd_head];
    assign o_e    = r_e[i_rd_head];

endmodule

// File: rtl/requant_param_sched.sv
// Per-head parameter scheduler: presents bias/M/E to the requant datapath aligned to its A stream.
module requant_param_sched
    import requant_pkg::*;
#(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 32,
    parameter int N_COLS  = 16,
    parameter int N_HEADS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [1:0]                 cfg_sel,
    input  logic [$clog2(N_HEADS)-1:0] cfg_head,
    input  logic [$clog2(N_COLS)-1:0]  cfg_col,
    input  logic [D_W_ACC-1:0]         cfg_data,
    input  logic                       start,
    input  logic [$clog2(N_HEADS)-1:0] head_sel,
    input  logic                       A_valid_in,
    input  logic                       A_last_in,
    input  logic                       back_ready_in,
    output logic [D_W_ACC-1:0]         bias_data_out,
    output logic                       bias_valid_out,
    output logic [3:0]                 bias_keep_out,
    output logic [D_W_ACC-1:0]         M_data_out,
    output logic                       M_valid_out,
    output logic [3:0]                 M_keep_out,
    output logic [D_W-1:0]             E_data_out,
    output logic                       E_valid_out,
    output logic [3:0]                 E_keep_out,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int HW = $clog2(N_HEADS);
    localparam int CW = $clog2(N_COLS);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [HW-1:0]         r_run_head;
    logic [CW-1:0]         r_col;
    logic [1:0]            r_drain_cnt;
    logic [A_PIPE_DLY-1:0] r_av_pipe;
    logic [A_PIPE_DLY-1:0] r_al_pipe;
    logic                  r_err;

    logic                  w_av_d2;
    logic                  w_al_d2;
    logic                  w_busy;
    logic                  w_acc;
    logic                  w_cfg_drop;
    logic                  w_tbl_we;
    logic                  w_drain_end;
    logic                  w_err_set;
    logic [D_W_ACC-1:0]    w_bias;
    logic [D_W_ACC-1:0]    w_m;
    logic [D_W-1:0]        w_e;

    assign w_av_d2     = r_av_pipe[A_PIPE_DLY-1];
    assign w_al_d2     = r_al_pipe[A_PIPE_DLY-1];
    assign w_busy      = (r_state != ST_IDLE);
    assign w_acc       = w_av_d2 && back_ready_in && (r_state == ST_RUN);
    assign w_drain_end = (r_state == ST_DRAIN) && (r_drain_cnt == 2'(DRAIN_CYC - 1));

    // Any write to the locked head (including the live bias entry) is refused, so reads see old data.
    assign w_cfg_drop = cfg_we && ((cfg_sel == CFG_RSVD) || (w_busy && (cfg_head == r_run_head)));
    assign w_tbl_we   = cfg_we && !w_cfg_drop;

    assign w_err_set = w_cfg_drop
                     || (start && w_busy)
                     || (w_av_d2 && (r_state != ST_RUN))
                     || (w_acc && w_al_d2 && (r_col != CW'(N_COLS - 1)));

    requant_param_tbl #(
        .D_W     (D_W),
        .D_W_ACC (D_W_ACC),
        .N_COLS  (N_COLS),
        .N_HEADS (N_HEADS),
        .HW      (HW),
        .CW      (CW)
    ) u_tbl (
        .i_clk     (clk),
        .i_we      (w_tbl_we),
        .i_sel     (cfg_sel),
        .i_wr_head (cfg_head),
        .i_wr_col  (cfg_col),
        .i_wr_data (cfg_data),
        .i_rd_head (r_run_head),
        .i_rd_col  (r_col),
        .o_bias    (w_bias),
        .o_m       (w_m),
        .o_e       (w_e)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_run_head  <= '0;
            r_col       <= '0;
            r_drain_cnt <= '0;
            r_av_pipe   <= '0;
            r_al_pipe   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_av_pipe <= {r_av_pipe[A_PIPE_DLY-2:0], A_valid_in};
            r_al_pipe <= {r_al_pipe[A_PIPE_DLY-2:0], A_last_in};
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if ((r_state == ST_IDLE) && start) begin
                r_run_head <= head_sel;
                r_col      <= '0;
            end else if (w_acc) begin
                r_col <= r_col + 1'b1;
            end
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 2'd1;
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        bias_data_out  = '0;
        bias_valid_out = 1'b0;
        M_data_out     = '0;
        M_valid_out    = 1'b0;
        E_data_out     = '0;
        E_valid_out    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                bias_valid_out = w_av_d2;
                bias_data_out  = w_bias;
                M_valid_out    = 1'b1;
                M_data_out     = w_m;
                E_valid_out    = 1'b1;
                E_data_out     = w_e;
                if (w_acc && w_al_d2) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                M_valid_out = 1'b1;
                M_data_out  = w_m;
                E_valid_out = 1'b1;
                E_data_out  = w_e;
                if (w_drain_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        bias_keep_out = bias_valid_out ? KEEP_ALL : 4'b0000;
        M_keep_out    = M_valid_out ? KEEP_ALL : 4'b0000;
        E_keep_out    = E_valid_out ? KEEP_ALL : 4'b0000;
        busy          = w_busy;
        done          = w_drain_end;
        err           = r_err;
    end

endmodule
